// File: rtl/mmio_timer_bank.sv
// mmio_timer_bank: memory-mapped bank of NUM_TIMERS independent compare timers
// on the vproc data-memory port. Each channel has CTRL/COMPARE/COUNT/STATUS
// words at BASE_ADDR + 4*c + {0,1,2,3}.
// Optional feature macro: TIMER_IRQ_EN (adds timer_irq_o and CTRL.IRQ_EN).
//
// Bus handshake: a request is a single-cycle pulse on vproc_mem_req_o sampled
// at a rising edge; exactly one cycle later vproc_mem_rvalid_i pulses for one
// cycle with rdata/err valid. There is no backpressure, so requests may be
// issued on consecutive cycles. Writes take effect on the sampling edge and
// reads return the register contents from before that edge.
module mmio_timer_bank #(
  parameter int          NUM_TIMERS    = 4,
  parameter int          COUNTER_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0115
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vproc_mem_req_o,
  input  logic [31:0] vproc_mem_addr_o,
  input  logic        vproc_mem_we_o,
  input  logic [3:0]  vproc_mem_be_o,
  input  logic [31:0] vproc_mem_wdata_o,
  output logic        vproc_mem_rvalid_i,
  output logic        vproc_mem_err_i,
  output logic [31:0] vproc_mem_rdata_i
`ifdef TIMER_IRQ_EN
  ,
  output logic [NUM_TIMERS-1:0] timer_irq_o
`endif
);

  localparam int              CW   = COUNTER_WIDTH;
  localparam logic [31:0]     SPAN = 32'(4 * NUM_TIMERS);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  // Bus decode
  logic [31:0] w_off;
  logic        w_hit;
  logic [3:0]  w_ch;
  logic [1:0]  w_reg;
  logic        w_wr;
  logic [31:0] w_mask;
  logic [31:0] w_rdata;

  assign w_off = vproc_mem_addr_o - BASE_ADDR;
  assign w_hit = (vproc_mem_addr_o >= BASE_ADDR) && (w_off < SPAN);
  assign w_ch  = w_off[5:2];
  assign w_reg = w_off[1:0];
  // A write with no byte lanes enabled is a complete no-op, side effects included.
  assign w_wr  = vproc_mem_req_o && vproc_mem_we_o && w_hit && (vproc_mem_be_o != 4'b0000);

  // Channel state
  logic [NUM_TIMERS-1:0] r_en, r_per, r_fired;
  logic [NUM_TIMERS-1:0] w_en_n, w_per_n, w_fired_n, w_expire;
  logic [CW-1:0]         r_cmp   [NUM_TIMERS];
  logic [CW-1:0]         r_cnt   [NUM_TIMERS];
  logic [CW-1:0]         w_cmp_n [NUM_TIMERS];
  logic [CW-1:0]         w_cnt_n [NUM_TIMERS];
`ifdef TIMER_IRQ_EN
  logic [NUM_TIMERS-1:0] r_irq_en, w_irq_en_n, r_irq;
`endif

  // Response registers
  logic        r_rvalid;
  logic        r_err;
  logic [31:0] r_rdata;

  // Merge write data into an old register value lane by lane, then truncate.
  function automatic logic [CW-1:0] f_merge(input logic [CW-1:0] old,
                                            input logic [31:0] wd,
                                            input logic [31:0] mask);
    return CW'((32'(old) & ~mask) | (wd & mask));
  endfunction

  // Expand byte enables into a bit mask
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < 4; b++) w_mask[8*b +: 8] = {8{vproc_mem_be_o[b]}};
  end

  // Detect the edge on which each running channel reaches its compare value
  always_comb begin
    for (int c = 0; c < NUM_TIMERS; c++)
      w_expire[c] = r_en[c] && (r_cmp[c] != '0) && ((r_cnt[c] + ONE) == r_cmp[c]);
  end

  // Next-state: counting first, then bus writes override the written register
  always_comb begin
    for (int c = 0; c < NUM_TIMERS; c++) begin
      w_en_n[c]    = r_en[c];
      w_per_n[c]   = r_per[c];
      w_fired_n[c] = r_fired[c];
      w_cmp_n[c]   = r_cmp[c];
      w_cnt_n[c]   = r_cnt[c];
`ifdef TIMER_IRQ_EN
      w_irq_en_n[c] = r_irq_en[c];
`endif
      if (r_en[c] && (r_cmp[c] != '0)) begin
        if (w_expire[c]) begin
          w_fired_n[c] = 1'b1;
          if (r_per[c]) begin
            w_cnt_n[c] = '0;
          end else begin
            w_cnt_n[c] = r_cmp[c];
            w_en_n[c]  = 1'b0;
          end
        end else begin
          w_cnt_n[c] = r_cnt[c] + ONE;
        end
      end
      if (w_wr && (w_ch == 4'(c))) begin
        case (w_reg)
          2'd0: begin
            if (vproc_mem_be_o[0]) begin
              w_en_n[c]  = vproc_mem_wdata_o[0];
              w_per_n[c] = vproc_mem_wdata_o[1];
`ifdef TIMER_IRQ_EN
              w_irq_en_n[c] = vproc_mem_wdata_o[2];
`endif
            end
          end
          2'd1: begin
            w_cmp_n[c]   = f_merge(r_cmp[c], vproc_mem_wdata_o, w_mask);
            w_cnt_n[c]   = '0;
            w_fired_n[c] = 1'b0;
          end
          2'd2: w_cnt_n[c] = f_merge(r_cnt[c], vproc_mem_wdata_o, w_mask);
          default: begin
            // An expiry on the same edge keeps FIRED set.
            if (vproc_mem_wdata_o[0] && !w_expire[c]) w_fired_n[c] = 1'b0;
          end
        endcase
      end
    end
  end

  // Read mux over pre-edge register contents
  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_TIMERS; c++) begin
      if (w_ch == 4'(c)) begin
        case (w_reg)
`ifdef TIMER_IRQ_EN
          2'd0:    w_rdata = {29'd0, r_irq_en[c], r_per[c], r_en[c]};
`else
          2'd0:    w_rdata = {29'd0, 1'b0, r_per[c], r_en[c]};
`endif
          2'd1:    w_rdata = 32'(r_cmp[c]);
          2'd2:    w_rdata = 32'(r_cnt[c]);
          default: w_rdata = {31'd0, r_fired[c]};
        endcase
      end
    end
  end

  // Channel registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en    <= '0;
      r_per   <= '0;
      r_fired <= '0;
      for (int c = 0; c < NUM_TIMERS; c++) begin
        r_cmp[c] <= '0;
        r_cnt[c] <= '0;
      end
`ifdef TIMER_IRQ_EN
      r_irq_en <= '0;
      r_irq    <= '0;
`endif
    end else begin
      r_en    <= w_en_n;
      r_per   <= w_per_n;
      r_fired <= w_fired_n;
      for (int c = 0; c < NUM_TIMERS; c++) begin
        r_cmp[c] <= w_cmp_n[c];
        r_cnt[c] <= w_cnt_n[c];
      end
`ifdef TIMER_IRQ_EN
      r_irq_en <= w_irq_en_n;
      r_irq    <= w_fired_n & w_irq_en_n;
`endif
    end
  end

  // Bus response: one-cycle rvalid, error for out-of-window addresses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= vproc_mem_req_o;
      r_err    <= vproc_mem_req_o && !w_hit;
      r_rdata  <= (vproc_mem_req_o && !vproc_mem_we_o && w_hit) ? w_rdata : '0;
    end
  end

  assign vproc_mem_rvalid_i = r_rvalid;
  assign vproc_mem_err_i    = r_err;
  assign vproc_mem_rdata_i  = r_rdata;
`ifdef TIMER_IRQ_EN
  assign timer_irq_o        = r_irq;
`endif

endmodule

// File: tb/tb_mmio_timer_bank.sv
// tb_mmio_timer_bank: directed and randomized bench for mmio_timer_bank.
// A second instance with an 8-bit counter shares the bus for truncation checks.
module tb_mmio_timer_bank;
  localparam int          NT   = 4;
  localparam logic [31:0] BASE = 32'h0000_0115;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        rvalid, err, rvalid8, err8;
  logic [31:0] rdata, rdata8;
`ifdef TIMER_IRQ_EN
  logic [NT-1:0] irq, irq8;
`endif

  int checks = 0;
  int errors = 0;

  mmio_timer_bank #(.NUM_TIMERS(NT), .COUNTER_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .vproc_mem_req_o(req), .vproc_mem_addr_o(addr), .vproc_mem_we_o(we),
    .vproc_mem_be_o(be), .vproc_mem_wdata_o(wdata),
    .vproc_mem_rvalid_i(rvalid), .vproc_mem_err_i(err), .vproc_mem_rdata_i(rdata)
`ifdef TIMER_IRQ_EN
    , .timer_irq_o(irq)
`endif
  );

  mmio_timer_bank #(.NUM_TIMERS(NT), .COUNTER_WIDTH(8), .BASE_ADDR(BASE)) dut8 (
    .clk(clk), .rst(rst),
    .vproc_mem_req_o(req), .vproc_mem_addr_o(addr), .vproc_mem_we_o(we),
    .vproc_mem_be_o(be), .vproc_mem_wdata_o(wdata),
    .vproc_mem_rvalid_i(rvalid8), .vproc_mem_err_i(err8), .vproc_mem_rdata_i(rdata8)
`ifdef TIMER_IRQ_EN
    , .timer_irq_o(irq8)
`endif
  );

  // Reference model: register file of the 32-bit instance
  logic [31:0] m_cmp [NT];
  logic [31:0] m_cnt [NT];
  logic        m_en [NT], m_per [NT], m_irqen [NT], m_fired [NT];
  logic [31:0] exp_rd;
  logic        exp_err, exp_rv;
`ifdef TIMER_IRQ_EN
  logic [NT-1:0] exp_irq;
`endif
  logic [31:0] obs_rd, obs_rd8;
  logic        obs_err, obs_rv;

  task automatic model_reset();
    for (int c = 0; c < NT; c++) begin
      m_cmp[c] = 0; m_cnt[c] = 0; m_en[c] = 0; m_per[c] = 0; m_irqen[c] = 0; m_fired[c] = 0;
    end
  endtask

  // One clock of the register bank as seen from the bus.
  task automatic model_step(input logic rq, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d);
    longint      off;
    int          ch, k;
    bit          hit;
    bit          fire [NT];
    logic [31:0] v;
    off = longint'(a) - longint'(BASE);
    hit = rq && (off >= 0) && (off < 4 * NT);
    ch  = hit ? int'(off / 4) : 0;
    k   = hit ? int'(off % 4) : 0;
    exp_rv = rq; exp_err = rq && !hit; exp_rd = 0;
    if (hit && !w) begin
      case (k)
        0:       exp_rd = {29'd0, m_irqen[ch], m_per[ch], m_en[ch]};
        1:       exp_rd = m_cmp[ch];
        2:       exp_rd = m_cnt[ch];
        default: exp_rd = {31'd0, m_fired[ch]};
      endcase
    end
    for (int c = 0; c < NT; c++) begin
      fire[c] = 0;
      if (m_en[c] && m_cmp[c] != 0) begin
        m_cnt[c] = m_cnt[c] + 1;
        if (m_cnt[c] == m_cmp[c]) begin
          fire[c] = 1; m_fired[c] = 1;
          if (m_per[c]) m_cnt[c] = 0; else m_en[c] = 0;
        end
      end
    end
    if (hit && w && b != 4'b0000) begin
      case (k)
        0: if (b[0]) begin
          m_en[ch] = d[0]; m_per[ch] = d[1];
`ifdef TIMER_IRQ_EN
          m_irqen[ch] = d[2];
`endif
        end
        1: begin
          v = m_cmp[ch];
          for (int i = 0; i < 4; i++) if (b[i]) v[8*i +: 8] = d[8*i +: 8];
          m_cmp[ch] = v; m_cnt[ch] = 0; m_fired[ch] = 0;
        end
        2: begin
          v = m_cnt[ch];
          for (int i = 0; i < 4; i++) if (b[i]) v[8*i +: 8] = d[8*i +: 8];
          m_cnt[ch] = v;
        end
        default: if (d[0] && !fire[ch]) m_fired[ch] = 0;
      endcase
    end
`ifdef TIMER_IRQ_EN
    for (int c = 0; c < NT; c++) exp_irq[c] = m_fired[c] & m_irqen[c];
`endif
  endtask

  // Driver tasks: one bus cycle, outputs captured 1ns after the sampling edge
  function automatic logic [31:0] reg_addr(input int ch, input int k);
    return BASE + 32'(4 * ch + k);
  endfunction

  task automatic bus(input logic rq, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    req = rq; we = w; addr = a; be = b; wdata = d;
    model_step(rq, w, a, b, d);
    @(posedge clk);
    #1;
    obs_rd = rdata; obs_err = err; obs_rv = rvalid; obs_rd8 = rdata8;
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
  endtask

  task automatic wr(input int ch, input int k, input logic [31:0] d);
    bus(1'b1, 1'b1, reg_addr(ch, k), 4'hF, d);
  endtask

  task automatic rd(input int ch, input int k);
    bus(1'b1, 1'b0, reg_addr(ch, k), 4'h0, 32'h0);
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got rvalid=%0b err=%0b rdata=%h want 0 0 0", rvalid, err, rdata);
    end
    rst = 1'b1;
    model_reset();
    for (int ch = 0; ch < NT; ch++)
      for (int k = 0; k < 4; k++) begin
        rd(ch, k);
        checks++;
        if (obs_rd !== 32'h0 || obs_err !== 1'b0 || obs_rv !== 1'b1) begin
          errors++;
          $display("FAIL reset_reg ch%0d k%0d got rdata=%h err=%0b rv=%0b want 0 0 1", ch, k, obs_rd, obs_err, obs_rv);
        end
      end
  endtask

  task automatic test_one_shot();
    wr(0, 1, 32'd5);
    wr(0, 0, 32'd1);
    for (int j = 1; j <= 7; j++) begin
      rd(0, 3);
      checks++;
      if (obs_rd !== ((j >= 6) ? 32'd1 : 32'd0)) begin
        errors++;
        $display("FAIL one_shot_status read%0d got %h want %h", j, obs_rd, (j >= 6) ? 32'd1 : 32'd0);
      end
    end
    rd(0, 2);
    checks++;
    if (obs_rd !== 32'd5) begin errors++; $display("FAIL one_shot_count got %h want 5", obs_rd); end
    rd(0, 0);
    checks++;
    if (obs_rd !== 32'd0) begin errors++; $display("FAIL one_shot_ctrl got %h want 0", obs_rd); end
  endtask

  task automatic test_periodic();
    wr(1, 1, 32'd3);
    wr(1, 0, 32'd3);
    for (int j = 1; j <= 6; j++) begin
      rd(1, 2);
      checks++;
      if (obs_rd !== 32'((j - 1) % 3)) begin
        errors++;
        $display("FAIL periodic_count read%0d got %h want %0d", j, obs_rd, (j - 1) % 3);
      end
    end
    rd(1, 3);
    checks++;
    if (obs_rd !== 32'd1) begin errors++; $display("FAIL periodic_fired got %h want 1", obs_rd); end
    wr(1, 3, 32'd1);
    for (int j = 1; j <= 3; j++) begin
      rd(1, 3);
      checks++;
      if (obs_rd !== ((j >= 2) ? 32'd1 : 32'd0)) begin
        errors++;
        $display("FAIL periodic_refire read%0d got %h want %h", j, obs_rd, (j >= 2) ? 32'd1 : 32'd0);
      end
    end
    wr(1, 0, 32'd0);
  endtask

  task automatic test_byte_enables();
    bus(1'b1, 1'b1, reg_addr(2, 1), 4'b0011, 32'hAABBCCDD);
    rd(2, 1);
    checks++;
    if (obs_rd !== 32'h0000CCDD || obs_rd8 !== 32'h000000DD) begin
      errors++;
      $display("FAIL be_compare got %h / %h want 0000ccdd / 000000dd", obs_rd, obs_rd8);
    end
    bus(1'b1, 1'b1, reg_addr(2, 1), 4'b0000, 32'h11223344);
    rd(2, 1);
    checks++;
    if (obs_rd !== 32'h0000CCDD || obs_rd8 !== 32'h000000DD) begin
      errors++;
      $display("FAIL be_zero got %h / %h want 0000ccdd / 000000dd", obs_rd, obs_rd8);
    end
    bus(1'b1, 1'b1, reg_addr(2, 2), 4'b1100, 32'hAABBCCDD);
    rd(2, 2);
    checks++;
    if (obs_rd !== 32'hAABB0000 || obs_rd8 !== 32'h0) begin
      errors++;
      $display("FAIL be_count got %h / %h want aabb0000 / 0", obs_rd, obs_rd8);
    end
    bus(1'b1, 1'b1, reg_addr(2, 0), 4'b1110, 32'h3);
    rd(2, 0);
    checks++;
    if (obs_rd !== 32'h0) begin errors++; $display("FAIL be_ctrl got %h want 0", obs_rd); end
  endtask

  task automatic test_errors();
    bus(1'b1, 1'b0, BASE - 32'd1, 4'h0, 32'h0);
    checks++;
    if (obs_err !== 1'b1 || obs_rd !== 32'h0 || obs_rv !== 1'b1) begin
      errors++;
      $display("FAIL err_below got err=%0b rdata=%h rv=%0b want 1 0 1", obs_err, obs_rd, obs_rv);
    end
    bus(1'b1, 1'b1, BASE + 32'(4 * NT), 4'hF, 32'h7);
    checks++;
    if (obs_err !== 1'b1) begin errors++; $display("FAIL err_above_wr got %0b want 1", obs_err); end
    bus(1'b1, 1'b0, BASE + 32'(4 * NT), 4'h0, 32'h0);
    checks++;
    if (obs_err !== 1'b1 || obs_rd !== 32'h0) begin
      errors++;
      $display("FAIL err_above_rd got err=%0b rdata=%h want 1 0", obs_err, obs_rd);
    end
    rd(0, 0);
    checks++;
    if (obs_err !== 1'b0 || obs_rd !== 32'h0) begin
      errors++;
      $display("FAIL err_no_alias got err=%0b rdata=%h want 0 0", obs_err, obs_rd);
    end
    rd(NT - 1, 3);
    checks++;
    if (obs_err !== 1'b0) begin errors++; $display("FAIL err_last_valid got %0b want 0", obs_err); end
  endtask

  task automatic test_conflict();
    wr(3, 1, 32'd2);
`ifdef TIMER_IRQ_EN
    wr(3, 0, 32'd5);
`else
    wr(3, 0, 32'd1);
`endif
    idle();
    wr(3, 3, 32'd1);
    rd(3, 3);
    checks++;
    if (obs_rd !== 32'd1) begin errors++; $display("FAIL conflict_fired got %h want 1", obs_rd); end
`ifdef TIMER_IRQ_EN
    idle();
    checks++;
    if (irq[3] !== 1'b1) begin errors++; $display("FAIL conflict_irq_hold got %0b want 1", irq[3]); end
`endif
    wr(3, 3, 32'd1);
`ifdef TIMER_IRQ_EN
    checks++;
    if (irq[3] !== 1'b0) begin errors++; $display("FAIL conflict_irq_clear got %0b want 0", irq[3]); end
`endif
    rd(3, 3);
    checks++;
    if (obs_rd !== 32'd0) begin errors++; $display("FAIL conflict_cleared got %h want 0", obs_rd); end
  endtask

  task automatic test_random();
    logic        rq, w;
    logic [31:0] a, d;
    logic [3:0]  b;
    for (int n = 0; n < 400; n++) begin
      rq = ($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 1));
      a  = BASE - 32'd2 + 32'($urandom_range(0, 4 * NT + 3));
      b  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      d  = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 9));
      bus(rq, w, a, b, d);
      checks++;
      if (obs_rv !== exp_rv || obs_err !== exp_err || (rq && !w && obs_rd !== exp_rd)) begin
        errors++;
        $display("FAIL random%0d addr=%h we=%0b got rv=%0b err=%0b rdata=%h want rv=%0b err=%0b rdata=%h",
                 n, a, w, obs_rv, obs_err, obs_rd, exp_rv, exp_err, exp_rd);
      end
`ifdef TIMER_IRQ_EN
      checks++;
      if (irq !== exp_irq) begin errors++; $display("FAIL random_irq%0d got %b want %b", n, irq, exp_irq); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    wr(0, 1, 32'd50);
    wr(0, 0, 32'd1);
    repeat (3) idle();
    rd(0, 2);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got rvalid=%0b err=%0b rdata=%h want 0 0 0", rvalid, err, rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle();
    for (int ch = 0; ch < NT; ch++)
      for (int k = 0; k < 4; k++) begin
        rd(ch, k);
        checks++;
        if (obs_rd !== 32'h0 || obs_err !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_reg ch%0d k%0d got %h err=%0b want 0 0", ch, k, obs_rd, obs_err);
        end
      end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_byte_enables();
    test_errors();
    test_conflict();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer_bank.md
# mmio_timer_bank

Memory-mapped bank of `NUM_TIMERS` independent compare timers on the vproc data-memory port. It generalises the single fixed-address digital timer into a parametrised channel array with one-shot and periodic modes, a readable live count and sticky expiry flags. It sits behind the MMU address decoder alongside the GPIO and SRAM regions.

## Interface
- `NUM_TIMERS`, 4: number of channels, 1–16.
- `COUNTER_WIDTH`, 32: counter and compare width, 8–32.
- `BASE_ADDR`, 32'h0000_0115: word address of channel 0 CTRL.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `vproc_mem_req_o` input 1: access request, one-cycle transaction.
- `vproc_mem_addr_o` input 32: word address.
- `vproc_mem_we_o` input 1: 1 write, 0 read.
- `vproc_mem_be_o` input 4: byte enables for writes.
- `vproc_mem_wdata_o` input 32: write data.
- `vproc_mem_rvalid_i` output 1: response valid, reads and writes.
- `vproc_mem_err_i` output 1: access error, qualified by rvalid.
- `vproc_mem_rdata_i` output 32: read data.

## Operation
- Channel c occupies addresses `BASE_ADDR + 4c + k`: k=0 CTRL, k=1 COMPARE, k=2 COUNT, k=3 STATUS.
- CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN (see Configuration); other bits read 0, writes ignored.
- COMPARE write: loads compare (truncated to `COUNTER_WIDTH`), clears COUNT to 0 and clears FIRED.
- COUNT write: loads counter; read returns live count zero-extended.
- STATUS: bit0 FIRED, sticky; write with bit0=1 clears it, bit0=0 no effect.
- Byte enables apply per byte to CTRL, COMPARE, COUNT; be=0 write is a legal no-op.
- Counting: each cycle with EN=1 and COMPARE≠0, counter increments. On the edge where counter would reach COMPARE: FIRED←1; PERIODIC=1 → counter←0; PERIODIC=0 → counter←COMPARE and EN←0.
- COMPARE=0: channel never counts or fires.
- Address outside `[BASE_ADDR, BASE_ADDR+4·NUM_TIMERS)`: err=1, rdata=0, no state change.
- Same-edge conflicts: bus write to a register takes precedence over counter update; expiry setting FIRED wins over STATUS clear in same cycle.
- Reset mid-count: all channels return to reset state immediately, no residual FIRED.

## Timing
- Reset values: all outputs 0; every CTRL, COMPARE, COUNT, STATUS register 0.
- Request sampled on rising edge N; write takes effect at edge N; rvalid=1 for exactly one cycle after edge N with rdata/err valid; zero wait states, back-to-back requests allowed.
- Read returns register value before any same-edge update.
- EN written at edge N with COUNT=0, COMPARE=K: FIRED=1 after edge N+K; periodic fires every K cycles thereafter.
- Outputs registered; no combinational path from bus inputs to outputs.

## Configuration
- `TIMER_IRQ_EN` defined: adds output `timer_irq_o` width `NUM_TIMERS`, bit c = FIRED[c] & IRQ_EN[c], registered, level until STATUS cleared; CTRL bit2 writable.
- Undefined: port absent, CTRL bit2 reads 0 and ignores writes; all other behaviour identical.

## Test plan
- Reset: assert rst=0 mid-count → every register reads 0, rvalid=0, err=0.
- One-shot: ch0 COMPARE=5, CTRL=1 → STATUS reads 0 for 4 cycles, 1 from cycle 5; COUNT holds 5; CTRL reads 0.
- Periodic: ch1 COMPARE=3, CTRL=3 → FIRED set at cycle 3; after clear, set again 3 cycles later; COUNT cycles 1,2,0.
- Byte enables: COMPARE write 32'hAABBCCDD be=4'b0011 over 0 → reads 32'h0000CCDD; `COUNTER_WIDTH`=8 → reads 32'h000000DD.
- Errors: addresses `BASE_ADDR-1` and `BASE_ADDR+4·NUM_TIMERS` → err=1, rdata=0, registers unchanged; valid address → err=0.
- Conflict: STATUS clear on expiry edge → FIRED reads 1; with `TIMER_IRQ_EN`, IRQ_EN=1 → timer_irq_o[c] high until later clear.
